// File: rtl/adc_sched_pkg.sv
// Shared types and default widths for the LTC2308 request scheduler.
package adc_sched_pkg;

   localparam int DEF_CHW = 3;
   localparam int DEF_DW  = 12;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         win,
   output logic [$clog2(N)-1:0] idx
);

   localparam int IW = $clog2(N);

   logic          found;
   logic [IW-1:0] cand;

   // NOTE: every combinational output gets a default before the search loop, so no latch can be inferred.
   always_comb begin
      win   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int i = 0; i < N; i++) begin
         cand = IW'((int'(ptr) + i) % N);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      if (found) win[idx] = 1'b1;
   end

endmodule

// File: rtl/adc_sched.sv
// Round-robin sharing of one ADC interface between NREQ requesters.
// Optional WAIT watchdog enabled by defining ADC_SCHED_WDOG_EN.
module adc_sched
   import adc_sched_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int CHW     = DEF_CHW,
   parameter int DW      = DEF_DW,
   parameter int TIMEOUT = 1023
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]     req,
   input  logic [NREQ*CHW-1:0] req_ch,
   output logic [NREQ-1:0]     gnt,
   output logic [NREQ-1:0]     rsp_valid,
   output logic [DW-1:0]       rsp_data,
   output logic [CHW-1:0]      rsp_ch,
   output logic                rsp_err,
   output logic                adc_start,
   output logic [CHW-1:0]      adc_ch,
   input  logic                adc_done,
   input  logic [DW-1:0]       adc_data
);

   localparam int IW = $clog2(NREQ);

   sched_state_t    state;
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   win_idx;
   logic [NREQ-1:0] win_oh;
   logic [NREQ-1:0] arb_win;
   logic [IW-1:0]   arb_idx;
   logic [CHW-1:0]  win_ch;
   logic            wd_expired;

   rr_arbiter #(.N(NREQ)) u_arb (
      .req (req),
      .ptr (ptr),
      .win (arb_win),
      .idx (arb_idx)
   );

   always_comb begin
      win_ch = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (arb_win[i]) win_ch = req_ch[i*CHW +: CHW];
      end
   end

`ifdef ADC_SCHED_WDOG_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] wd_cnt;

   // Counts WAIT cycles from 0; parks at TIMEOUT until the FSM leaves WAIT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wd_cnt <= '0;
      end else if (state != WAIT) begin
         wd_cnt <= '0;
      end else if (!wd_expired) begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end

   assign wd_expired = (wd_cnt == TW'(TIMEOUT));
`else
   logic unused_timeout;

   assign unused_timeout = (TIMEOUT != 0);
   assign wd_expired     = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   // NOTE: the async reset clears every output and the latched winner, discarding any in-flight conversion.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         ptr       <= '0;
         win_idx   <= '0;
         win_oh    <= '0;
         gnt       <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
         rsp_ch    <= '0;
         rsp_err   <= 1'b0;
         adc_start <= 1'b0;
         adc_ch    <= '0;
      end else begin
         gnt       <= '0;
         adc_start <= 1'b0;
         rsp_valid <= '0;
         unique case (state)
            IDLE: begin
               if (|req) begin
                  win_idx   <= arb_idx;
                  win_oh    <= arb_win;
                  adc_ch    <= win_ch;
                  gnt       <= arb_win;
                  adc_start <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: state <= WAIT;
            WAIT: begin
               // A completion on the expiry cycle takes priority over the timeout.
               if (adc_done) begin
                  rsp_data  <= adc_data;
                  rsp_ch    <= adc_ch;
                  rsp_err   <= 1'b0;
                  rsp_valid <= win_oh;
                  state     <= RESP;
               end else if (wd_expired) begin
                  rsp_data  <= '0;
                  rsp_ch    <= adc_ch;
                  rsp_err   <= 1'b1;
                  rsp_valid <= win_oh;
                  state     <= RESP;
               end
            end
            RESP: begin
               ptr   <= (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_sched.sv
// Directed, table-driven bench for adc_sched; watchdog sequences need ADC_SCHED_WDOG_EN.
module tb_adc_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [11:0] req_ch;
   logic [3:0]  gnt;
   logic [3:0]  rsp_valid;
   logic [11:0] rsp_data;
   logic [2:0]  rsp_ch;
   logic        rsp_err;
   logic        adc_start;
   logic [2:0]  adc_ch;
   logic        adc_done;
   logic [11:0] adc_data;

   int n_vec  = 0;
   int n_miss = 0;

   adc_sched #(.NREQ(4), .CHW(3), .DW(12), .TIMEOUT(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .req_ch    (req_ch),
      .gnt       (gnt),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_ch    (rsp_ch),
      .rsp_err   (rsp_err),
      .adc_start (adc_start),
      .adc_ch    (adc_ch),
      .adc_done  (adc_done),
      .adc_data  (adc_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  req;
      logic        done;
      logic [11:0] data;
      logic [3:0]  gnt;
      logic [3:0]  rv;
      logic        st;
      logic [2:0]  ach;
      logic [11:0] rd;
      logic [2:0]  rch;
      logic        err;
   } vec_t;

   vec_t tbl[13];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_outs(input vec_t v, input string tag);
      check({tag, ".gnt"},       32'(gnt),       32'(v.gnt));
      check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(v.rv));
      check({tag, ".adc_start"}, 32'(adc_start), 32'(v.st));
      check({tag, ".adc_ch"},    32'(adc_ch),    32'(v.ach));
      check({tag, ".rsp_data"},  32'(rsp_data),  32'(v.rd));
      check({tag, ".rsp_ch"},    32'(rsp_ch),    32'(v.rch));
      check({tag, ".rsp_err"},   32'(rsp_err),   32'(v.err));
   endtask

   // Waits for a grant (bounded), then answers it with adc_done in the first WAIT cycle.
   task automatic expect_txn(input int idx, input logic [2:0] ch, input logic [11:0] d);
      int n = 0;
      while (gnt == 4'b0000 && n < 20) begin
         step();
         n++;
      end
      check($sformatf("txn%0d.gnt_latency", idx), 32'(n), 32'd1);
      check($sformatf("txn%0d.gnt", idx), 32'(gnt), 32'(4'b0001 << idx));
      check($sformatf("txn%0d.adc_start", idx), 32'(adc_start), 32'd1);
      check($sformatf("txn%0d.adc_ch", idx), 32'(adc_ch), 32'(ch));
      step();
      adc_done = 1'b1;
      adc_data = d;
      step();
      adc_done = 1'b0;
      check($sformatf("txn%0d.rsp_valid", idx), 32'(rsp_valid), 32'(4'b0001 << idx));
      check($sformatf("txn%0d.rsp_data", idx), 32'(rsp_data), 32'(d));
      check($sformatf("txn%0d.rsp_ch", idx), 32'(rsp_ch), 32'(ch));
      step();
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, expected $finish");
      $fatal(1);
   end

   initial begin
      // Channel map for table: ch0=2, ch1=5, ch2=3, ch3=4
      //               req    done data    gnt    rv     st    ach   rd       rch   err
      tbl[0]  = '{4'b0000, 1'b0, 12'h000, 4'b0000, 4'b0000, 1'b0, 3'd0, 12'h000, 3'd0, 1'b0};
      tbl[1]  = '{4'b0010, 1'b0, 12'h000, 4'b0010, 4'b0000, 1'b1, 3'd5, 12'h000, 3'd0, 1'b0};
      tbl[2]  = '{4'b0000, 1'b0, 12'h000, 4'b0000, 4'b0000, 1'b0, 3'd5, 12'h000, 3'd0, 1'b0};
      tbl[3]  = '{4'b0000, 1'b0, 12'h000, 4'b0000, 4'b0000, 1'b0, 3'd5, 12'h000, 3'd0, 1'b0};
      tbl[4]  = '{4'b0000, 1'b1, 12'hA5C, 4'b0000, 4'b0010, 1'b0, 3'd5, 12'hA5C, 3'd5, 1'b0};
      tbl[5]  = '{4'b0000, 1'b0, 12'h000, 4'b0000, 4'b0000, 1'b0, 3'd5, 12'hA5C, 3'd5, 1'b0};
      tbl[6]  = '{4'b0000, 1'b1, 12'h123, 4'b0000, 4'b0000, 1'b0, 3'd5, 12'hA5C, 3'd5, 1'b0};
      tbl[7]  = '{4'b0001, 1'b0, 12'h000, 4'b0001, 4'b0000, 1'b1, 3'd2, 12'hA5C, 3'd5, 1'b0};
      tbl[8]  = '{4'b0000, 1'b0, 12'h000, 4'b0000, 4'b0000, 1'b0, 3'd2, 12'hA5C, 3'd5, 1'b0};
      tbl[9]  = '{4'b0000, 1'b1, 12'h3FF, 4'b0000, 4'b0001, 1'b0, 3'd2, 12'h3FF, 3'd2, 1'b0};
      tbl[10] = '{4'b0000, 1'b1, 12'h777, 4'b0000, 4'b0000, 1'b0, 3'd2, 12'h3FF, 3'd2, 1'b0};
      tbl[11] = '{4'b0000, 1'b0, 12'h000, 4'b0000, 4'b0000, 1'b0, 3'd2, 12'h3FF, 3'd2, 1'b0};
      tbl[12] = '{4'b1111, 1'b0, 12'h000, 4'b0010, 4'b0000, 1'b1, 3'd5, 12'h3FF, 3'd2, 1'b0};

      reset    = 1'b1;
      req      = '0;
      req_ch   = {3'd4, 3'd3, 3'd5, 3'd2};
      adc_done = 1'b0;
      adc_data = '0;
      step();
      step();
      reset = 1'b0;
      step();

      // Single requester, stray strobes in IDLE and RESP, and first rotation step.
      for (int i = 0; i < 13; i++) begin
         req      = tbl[i].req;
         adc_done = tbl[i].done;
         adc_data = tbl[i].data;
         step();
         check_outs(tbl[i], $sformatf("v%0d", i));
      end

      // Round robin with all requests held; channel of requester i is i+1.
      req      = '0;
      adc_done = 1'b0;
      reset    = 1'b1;
      step();
      reset  = 1'b0;
      req_ch = {3'd4, 3'd3, 3'd2, 3'd1};
      step();
      req = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         expect_txn(k % 4, 3'(k % 4 + 1), 12'(12'h100 + k));
      end

      // Pointer wrap: after grant 3 only requesters 0 and 2 ask.
      req = 4'b0101;
      expect_txn(0, 3'd1, 12'h0C0);
      expect_txn(2, 3'd3, 12'h0C2);
      req = 4'b0000;
      step();

      // Reset two cycles after adc_start, late adc_done must be dropped.
      req = 4'b1000;
      expect_txn(3, 3'd4, 12'hBEE);
      req = 4'b0100;
      step();
      check("rst.gnt_before", 32'(gnt), 32'(4'b0100));
      req = 4'b0000;
      step();
      step();
      reset = 1'b1;
      #1;
      check("rst.gnt",       32'(gnt),       32'd0);
      check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst.rsp_data",  32'(rsp_data),  32'd0);
      check("rst.rsp_ch",    32'(rsp_ch),    32'd0);
      check("rst.rsp_err",   32'(rsp_err),   32'd0);
      check("rst.adc_start", 32'(adc_start), 32'd0);
      check("rst.adc_ch",    32'(adc_ch),    32'd0);
      step();
      step();
      reset    = 1'b0;
      adc_done = 1'b1;
      adc_data = 12'hFFF;
      step();
      adc_done = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("rst.late_done_rv", 32'(rsp_valid), 32'd0);
         step();
      end
      check("rst.rsp_data_after", 32'(rsp_data), 32'd0);
      req = 4'b1111;
      expect_txn(0, 3'd1, 12'h321);
      req = 4'b0000;
      step();

`ifdef ADC_SCHED_WDOG_EN
      // Timeout with no adc_done: response 17 cycles after WAIT entry.
      req = 4'b0010;
      step();
      check("wd1.gnt", 32'(gnt), 32'(4'b0010));
      req = 4'b0000;
      for (int s = 1; s <= 17; s++) begin
         step();
         check($sformatf("wd1.quiet%0d", s), 32'(rsp_valid), 32'd0);
      end
      step();
      check("wd1.rsp_valid", 32'(rsp_valid), 32'(4'b0010));
      check("wd1.rsp_err",   32'(rsp_err),   32'd1);
      check("wd1.rsp_data",  32'(rsp_data),  32'd0);
      check("wd1.rsp_ch",    32'(rsp_ch),    32'd2);
      step();

      // adc_done on the expiry cycle wins.
      req = 4'b0100;
      step();
      check("wd2.gnt", 32'(gnt), 32'(4'b0100));
      req = 4'b0000;
      for (int s = 1; s <= 17; s++) begin
         step();
      end
      check("wd2.quiet", 32'(rsp_valid), 32'd0);
      adc_done = 1'b1;
      adc_data = 12'h5A5;
      step();
      adc_done = 1'b0;
      check("wd2.rsp_valid", 32'(rsp_valid), 32'(4'b0100));
      check("wd2.rsp_err",   32'(rsp_err),   32'd0);
      check("wd2.rsp_data",  32'(rsp_data),  32'h5A5);
      step();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
